// File: rtl/de_hazard_ctrl_pkg.sv
// rtl/de_hazard_ctrl_pkg.sv - shared encodings and compare helper for the D/E hazard controller
package hazard_pkg;

   // Forwarding mux selects for the execute-stage ALU operands
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // HI/LO unit sequencer states
   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // Register 0 is hardwired to zero, so it never creates a dependency
   function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
      return (dst != 5'd0) && (dst == src);
   endfunction

endpackage

// File: rtl/de_hazard_ctrl_if.sv
// rtl/de_hazard_ctrl_if.sv - pipeline-side signal bundle between the datapath and the hazard controller
interface de_hazard_if;
   logic [4:0]  rsD;
   logic [4:0]  rtD;
   logic        BranchD;
   logic        BranchTakenD;
   logic        HiLoUseD;
   logic [4:0]  rsE;
   logic [4:0]  rtE;
   logic [4:0]  WriteRegE;
   logic        RegWriteE;
   logic        MemReadE;
   logic        MultDivStartE;
   logic        MultDivOpE;
   logic [4:0]  WriteRegM;
   logic        RegWriteM;
   logic        MemReadM;
   logic [4:0]  WriteRegW;
   logic        RegWriteW;
   logic        StallF;
   logic        StallD;
   logic        FlushD;
   logic        FlushE;
   logic [1:0]  ForwardAE;
   logic [1:0]  ForwardBE;
   logic        MdBusy;
   logic        MdDone;
   logic [31:0] StallCount;

   // Datapath side: supplies stage fields, consumes control
   modport master (
      output rsD, rtD, BranchD, BranchTakenD, HiLoUseD,
      output rsE, rtE, WriteRegE, RegWriteE, MemReadE, MultDivStartE, MultDivOpE,
      output WriteRegM, RegWriteM, MemReadM, WriteRegW, RegWriteW,
      input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
      input  MdBusy, MdDone, StallCount
   );

   // Hazard controller side
   modport slave (
      input  rsD, rtD, BranchD, BranchTakenD, HiLoUseD,
      input  rsE, rtE, WriteRegE, RegWriteE, MemReadE, MultDivStartE, MultDivOpE,
      input  WriteRegM, RegWriteM, MemReadM, WriteRegW, RegWriteW,
      output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
      output MdBusy, MdDone, StallCount
   );
endinterface

// File: rtl/de_hazard_ctrl_md_seq.sv
// rtl/de_hazard_ctrl_md_seq.sv - MULT/DIV occupancy sequencer with down-counter
module md_seq
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic op,
   input  logic hilo_use,
   output logic md_busy,
   output logic md_done,
   output logic md_block
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES);
   // Load value is cycles-2: one cycle is spent entering BUSY and one in DONE
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

   md_state_e        state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             md_busy_d, md_busy_q;
   logic             md_done_d, md_done_q;

   // Next-state, counter and registered-output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               state_d = MD_BUSY;
               cnt_d   = op ? DIV_LOAD : MULT_LOAD;
            end
         end
         MD_BUSY: begin
            // A start here cannot happen legally (decode is held); it is ignored
            if (cnt_q == '0) state_d = MD_DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         MD_DONE: begin
            if (start) begin
               state_d = MD_BUSY;
               cnt_d   = op ? DIV_LOAD : MULT_LOAD;
            end else begin
               state_d = MD_IDLE;
            end
         end
         default: state_d = MD_IDLE;
      endcase
      if (rst) begin
         state_d = MD_IDLE;
         cnt_d   = '0;
      end
      md_busy_d = (state_d != MD_IDLE);
      md_done_d = (state_d == MD_DONE);
   end

   // State, counter and output registers
   always_ff @(posedge clk) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
      md_done_q <= md_done_d;
   end

   // HI/LO consumers wait while the unit computes or a new op is entering it
   always_comb begin
      md_block = hilo_use & ((state_q == MD_BUSY) | start);
   end

   assign md_busy = md_busy_q;
   assign md_done = md_done_q;

endmodule

// File: rtl/de_hazard_ctrl.sv
// rtl/de_hazard_ctrl.sv - decode/execute hazard detection, forwarding and stall accounting
module de_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32
) (
   input logic         clk,
   input logic         rst,
   de_hazard_if.slave  hz
);

   logic        lduse, brhaz, md_block, stall;
   logic        md_busy, md_done;
   logic [31:0] stall_count_d, stall_count_q;

   md_seq #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_seq (
      .clk      (clk),
      .rst      (rst),
      .start    (hz.MultDivStartE),
      .op       (hz.MultDivOpE),
      .hilo_use (hz.HiLoUseD),
      .md_busy  (md_busy),
      .md_done  (md_done),
      .md_block (md_block)
   );

   // Hazard detection; stall has priority over a taken-branch flush
   always_comb begin
      lduse = hz.MemReadE & hz.RegWriteE &
              (reg_match(hz.WriteRegE, hz.rsD) | reg_match(hz.WriteRegE, hz.rtD));
      brhaz = hz.BranchD &
              ((hz.RegWriteE & (reg_match(hz.WriteRegE, hz.rsD) | reg_match(hz.WriteRegE, hz.rtD))) |
               (hz.MemReadM  & (reg_match(hz.WriteRegM, hz.rsD) | reg_match(hz.WriteRegM, hz.rtD))));
      stall = ~rst & (lduse | brhaz | md_block);
      hz.StallF = stall;
      hz.StallD = stall;
      hz.FlushE = stall;
      hz.FlushD = ~rst & hz.BranchTakenD & ~stall;
   end

   // Operand forwarding; the younger MEM result beats WB
   always_comb begin
      hz.ForwardAE = FWD_REG;
      hz.ForwardBE = FWD_REG;
      if (!rst) begin
         if (hz.RegWriteM && reg_match(hz.WriteRegM, hz.rsE))      hz.ForwardAE = FWD_MEM;
         else if (hz.RegWriteW && reg_match(hz.WriteRegW, hz.rsE)) hz.ForwardAE = FWD_WB;
         if (hz.RegWriteM && reg_match(hz.WriteRegM, hz.rtE))      hz.ForwardBE = FWD_MEM;
         else if (hz.RegWriteW && reg_match(hz.WriteRegW, hz.rtE)) hz.ForwardBE = FWD_WB;
      end
   end

   // Saturating count of decode-stall cycles
   always_comb begin
      stall_count_d = stall_count_q;
      if (rst)                                     stall_count_d = '0;
      else if (stall && (stall_count_q != '1))     stall_count_d = stall_count_q + 32'd1;
   end

   // Stall counter register
   always_ff @(posedge clk) begin
      stall_count_q <= stall_count_d;
   end

   assign hz.MdBusy     = md_busy;
   assign hz.MdDone     = md_done;
   assign hz.StallCount = stall_count_q;

endmodule
